// File: rtl/uart_rx_if.sv
// Serial receive bundle: the raw line into the receiver and the decoded byte,
// strobe and status flags coming back out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  rx_data, rx_valid, rx_busy, parity_err, frame_err
    );

    // Receiver side
    modport slave (
        input  rx,
        output rx_data, rx_valid, rx_busy, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver. Oversamples the asynchronous line with clk, qualifies the
// start bit at mid-bit, shifts 8 data bits LSB first, checks optional parity
// and 1 or 2 stop bits, then presents the byte with a one-cycle strobe.
module uart_rx #(
    parameter int INPUT_CLK  = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_BIT = 0
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int CLKS_PER_BIT = INPUT_CLK / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic HAS_PAR   = (PARITY_BIT != 0) ? 1'b1 : 1'b0;
    localparam logic ODD_PAR   = (PARITY_BIT == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t           state_reg;
    logic [2:0]       sync_reg;      // [0],[1] synchronizer, [2] edge-detect delay
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic             stop_idx_reg;
    logic [7:0]       shift_reg;
    logic             par_err_reg;
    logic             ferr_acc_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_valid_reg;
    logic             rx_busy_reg;
    logic             parity_err_reg;
    logic             frame_err_reg;

    logic rx_s;
    logic rx_d;

    assign rx_s = sync_reg[1];
    assign rx_d = sync_reg[2];

    // Bring the asynchronous line into clk and keep one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], bus.rx};
        end
    end

    // Frame FSM: every output is registered here so the strobe is glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            stop_idx_reg   <= 1'b0;
            shift_reg      <= '0;
            par_err_reg    <= 1'b0;
            ferr_acc_reg   <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_busy_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    rx_busy_reg <= 1'b0;
                    // Only a true high-to-low transition starts a frame; a stuck-low line never does
                    if (rx_d && !rx_s) begin
                        state_reg   <= START;
                        cnt_reg     <= '0;
                        rx_busy_reg <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_END) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            // Line went back high by mid start bit: treat as a glitch
                            state_reg   <= IDLE;
                            rx_busy_reg <= 1'b0;
                        end else begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_END) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg    <= HAS_PAR ? PARITY : STOP;
                            stop_idx_reg <= 1'b0;
                            ferr_acc_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_reg == BIT_END) begin
                        cnt_reg     <= '0;
                        // Even: data^bit must be 0; odd: must be 1
                        par_err_reg <= (^shift_reg) ^ rx_s ^ ODD_PAR;
                        state_reg   <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_END) begin
                        cnt_reg <= '0;
                        if (!rx_s) begin
                            ferr_acc_reg <= 1'b1;
                        end
                        // Leave at mid stop bit so a back-to-back start edge is still seen
                        if (stop_idx_reg == LAST_STOP) begin
                            state_reg <= DONE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    rx_data_reg    <= shift_reg;
                    parity_err_reg <= HAS_PAR & par_err_reg;
                    frame_err_reg  <= ferr_acc_reg;
                    rx_valid_reg   <= 1'b1;
                    rx_busy_reg    <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data    = rx_data_reg;
    assign bus.rx_valid   = rx_valid_reg;
    assign bus.rx_busy    = rx_busy_reg;
    assign bus.parity_err = parity_err_reg;
    assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Three receivers with different framing
// (8N1, 8E2, 8O1) each get their own line; a byte-level scoreboard predicts
// data and error flags from the bits actually put on the wire.
module tb_uart_rx;
    localparam int INPUT_CLK = 16_000_000;
    localparam int BAUD      = 1_000_000;
    localparam int CPB       = INPUT_CLK / BAUD;   // 16 clocks per bit
    localparam int HALF      = CPB / 2;
    localparam longint LAT   = 3 + HALF + 9 * CPB; // nominal 8N1 latency

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        longint     t;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] line = 3'b111;
    longint     cyc = 0;

    int n_asserts = 0;
    int n_fail = 0;

    rec_t got0[$], got1[$], got2[$];
    rec_t exp0[$], exp1[$], exp2[$];

    uart_rx_if bus0();
    uart_rx_if bus1();
    uart_rx_if bus2();

    assign bus0.rx = line[0];
    assign bus1.rx = line[1];
    assign bus2.rx = line[2];

    uart_rx #(.INPUT_CLK(INPUT_CLK), .BAUD_RATE(BAUD), .STOP_BITS(1), .PARITY_BIT(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    uart_rx #(.INPUT_CLK(INPUT_CLK), .BAUD_RATE(BAUD), .STOP_BITS(2), .PARITY_BIT(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    uart_rx #(.INPUT_CLK(INPUT_CLK), .BAUD_RATE(BAUD), .STOP_BITS(1), .PARITY_BIT(2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe; a strobe lasting two cycles shows up as an extra record
    always @(negedge clk) begin
        if (bus0.rx_valid) got0.push_back('{bus0.rx_data, bus0.parity_err, bus0.frame_err, cyc});
        if (bus1.rx_valid) got1.push_back('{bus1.rx_data, bus1.parity_err, bus1.frame_err, cyc});
        if (bus2.rx_valid) got2.push_back('{bus2.rx_data, bus2.parity_err, bus2.frame_err, cyc});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int par_mode(input int sel);
        return (sel == 1) ? 1 : ((sel == 2) ? 2 : 0);
    endfunction

    function automatic int n_stop(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    task automatic wait_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Drive one frame on line[sel] and record what a correct receiver must report
    task automatic send(input int sel, input logic [7:0] d, input logic pbit,
                        input logic [1:0] stopv, input logic end_lvl, input int gap_bits);
        rec_t e;
        int   pm;
        int   ns;
        pm = par_mode(sel);
        ns = n_stop(sel);
        e.d  = d;
        e.pe = (pm == 0) ? 1'b0 : (($countones({d, pbit}) % 2) != ((pm == 2) ? 1 : 0));
        e.fe = 1'b0;
        for (int s = 0; s < ns; s++) if (stopv[s] == 1'b0) e.fe = 1'b1;
        e.t  = 0;
        case (sel)
            0: exp0.push_back(e);
            1: exp1.push_back(e);
            default: exp2.push_back(e);
        endcase
        line[sel] = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            line[sel] = d[i];
            wait_bits(1);
        end
        if (pm != 0) begin
            line[sel] = pbit;
            wait_bits(1);
        end
        for (int s = 0; s < ns; s++) begin
            line[sel] = stopv[s];
            wait_bits(1);
        end
        line[sel] = end_lvl;
        wait_bits(gap_bits);
    endtask

    // Compare everything received on one receiver against the predictions, then clear
    task automatic compare(input int sel, input string tag);
        rec_t g;
        rec_t e;
        int   ng;
        int   ne;
        case (sel)
            0: begin ng = got0.size(); ne = exp0.size(); end
            1: begin ng = got1.size(); ne = exp1.size(); end
            default: begin ng = got2.size(); ne = exp2.size(); end
        endcase
        chk({tag, "_count"}, 64'(ng), 64'(ne));
        for (int i = 0; i < ne; i++) begin
            g.d = 'x; g.pe = 1'bx; g.fe = 1'bx; g.t = 0;
            case (sel)
                0: begin e = exp0.pop_front(); if (got0.size() > 0) g = got0.pop_front(); end
                1: begin e = exp1.pop_front(); if (got1.size() > 0) g = got1.pop_front(); end
                default: begin e = exp2.pop_front(); if (got2.size() > 0) g = got2.pop_front(); end
            endcase
            chk({tag, "_data"}, 64'(g.d), 64'(e.d));
            chk({tag, "_perr"}, 64'(g.pe), 64'(e.pe));
            chk({tag, "_ferr"}, 64'(g.fe), 64'(e.fe));
        end
        case (sel)
            0: got0.delete();
            1: got1.delete();
            default: got2.delete();
        endcase
    endtask

    initial begin
        longint t_drop;
        longint lat;
        logic [7:0] d;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_data", 64'(bus0.rx_data), 64'h0);
        chk("rst_valid", 64'(bus0.rx_valid), 64'h0);
        chk("rst_busy", 64'(bus0.rx_busy), 64'h0);
        chk("rst_perr", 64'(bus1.parity_err), 64'h0);
        chk("rst_ferr", 64'(bus0.frame_err), 64'h0);
        reset = 1'b0;
        wait_bits(2);

        // Single 8N1 frame 0x3D with latency check
        t_drop = cyc;
        send(0, 8'h3D, 1'b0, 2'b11, 1'b1, 3);
        lat = (got0.size() > 0) ? (got0[0].t - t_drop) : -1;
        chk("latency_ok", 64'((lat >= LAT - 2) && (lat <= LAT + 2)), 64'h1);
        chk("busy_after", 64'(bus0.rx_busy), 64'h0);
        compare(0, "f3d");

        // Stream of bytes in order
        send(0, 8'h3D, 1'b0, 2'b11, 1'b1, 2);
        send(0, 8'hC3, 1'b0, 2'b11, 1'b1, 2);
        send(0, 8'hAA, 1'b0, 2'b11, 1'b1, 2);
        send(0, 8'h55, 1'b0, 2'b11, 1'b1, 2);
        compare(0, "seq4");

        // Reset during data bit 4 (0xC3 has bit 4 low)
        d = 8'hC3;
        line[0] = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            line[0] = d[i];
            wait_bits(1);
        end
        line[0] = d[4];
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        line[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_data", 64'(bus0.rx_data), 64'h0);
        chk("abort_valid", 64'(bus0.rx_valid), 64'h0);
        chk("abort_busy", 64'(bus0.rx_busy), 64'h0);
        chk("abort_ferr", 64'(bus0.frame_err), 64'h0);
        wait_bits(3);
        compare(0, "abort");
        send(0, 8'hC3, 1'b0, 2'b11, 1'b1, 2);
        compare(0, "after_abort");

        // Back-to-back frames, start bit right after stop bit
        send(0, 8'h00, 1'b0, 2'b11, 1'b1, 0);
        send(0, 8'hFF, 1'b0, 2'b11, 1'b1, 2);
        lat = (got0.size() > 1) ? (got0[1].t - got0[0].t) : -1;
        chk("b2b_spacing_ok", 64'((lat >= 10 * CPB - 1) && (lat <= 10 * CPB + 1)), 64'h1);
        compare(0, "b2b");

        // Short low glitch on idle line
        line[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_hi", 64'(bus0.rx_busy), 64'h1);
        @(negedge clk);
        line[0] = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("glitch_busy_lo", 64'(bus0.rx_busy), 64'h0);
        wait_bits(2);
        compare(0, "glitch");

        // Stop bit low then line stuck low: one frame with frame error, nothing after
        send(0, 8'h55, 1'b0, 2'b00, 1'b0, 20);
        chk("stuck_busy", 64'(bus0.rx_busy), 64'h0);
        compare(0, "stuck");
        line[0] = 1'b1;
        wait_bits(2);
        send(0, 8'h3D, 1'b0, 2'b11, 1'b1, 2);
        compare(0, "recover");

        // Directed parity cases
        send(1, 8'hAA, 1'b0, 2'b11, 1'b1, 2);
        send(1, 8'hAA, 1'b1, 2'b11, 1'b1, 2);
        compare(1, "even");
        send(2, 8'hAA, 1'b1, 2'b11, 1'b1, 2);
        send(2, 8'hAA, 1'b0, 2'b11, 1'b1, 2);
        compare(2, "odd");

        // Randomized frames on all three framings
        for (int k = 0; k < 12; k++) begin
            send(0, 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11, 1'b1, 2);
            send(1, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11, 1'b1, 2);
            send(2, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 1'b1, 2);
        end
        compare(0, "rand_8n1");
        compare(1, "rand_8e2");
        compare(2, "rand_8o1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
